// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive pair: state encodings,
// frame geometry and the bit-period clamp used at byte acceptance.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_BAUD_W    = 18;

  typedef enum logic [2:0] {
    s_IDLE         = 3'b000,
    s_TX_START_BIT = 3'b001,
    s_TX_DATA_BIT  = 3'b010,
    s_TX_STOP_BIT  = 3'b011,
    s_CLEANUP      = 3'b100
  } uart_state_e;

  function automatic logic [UART_BAUD_W-1:0] clamp_period(
    input logic [UART_BAUD_W-1:0] period,
    input logic [UART_BAUD_W-1:0] min_period
  );
    return (period < min_period) ? min_period : period;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable bit-period timer: after a load, bit_tick pulses on every Nth
// enabled cycle, where N is the period captured at load time.
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic                   internal_clock,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   enable,
  input  logic [UART_BAUD_W-1:0] period,
  output logic                   bit_tick
);

  logic [UART_BAUD_W-1:0] period_reg;
  logic [UART_BAUD_W-1:0] count_reg;

  // Period is held locally so mid-frame changes on the input cannot disturb timing.
  assign bit_tick = enable & ~load & (count_reg == (period_reg - UART_BAUD_W'(1)));

  always_ff @(posedge internal_clock) begin
    if (reset) begin
      period_reg <= '0;
      count_reg  <= '0;
    end else if (load) begin
      period_reg <= period;
      count_reg  <= '0;
    end else if (enable) begin
      count_reg <= bit_tick ? '0 : count_reg + UART_BAUD_W'(1);
    end else begin
      count_reg <= '0;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit stage: one byte per valid/ready handshake, framed as start,
// eight data bits LSB first and one or two stop bits.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int STOP_BITS        = 1,
  parameter int CLK_PERS_BIT_MIN = 2
) (
  input  logic                   internal_clock,
  input  logic                   reset,
  input  logic [UART_BAUD_W-1:0] CLK_PERS_BIT,
  input  logic                   Tx_Valid,
  input  logic [7:0]             Tx_Byte,
  output logic                   Tx_Ready,
  output logic                   TX_Data,
  output logic                   Tx_Active,
  output logic                   Tx_Done
);

  localparam logic STOP_LAST = (STOP_BITS == 2);
  localparam logic [UART_BAUD_W-1:0] PERIOD_MIN = UART_BAUD_W'(CLK_PERS_BIT_MIN);

  uart_state_e state_reg;
  logic [UART_DATA_BITS-1:0] shift_reg;
  logic [2:0]                bit_index_reg;
  logic                      stop_count_reg;
  logic                      tx_data_reg;
  logic                      tx_active_reg;
  logic                      tx_done_reg;
  logic                      accept;
  logic                      bit_tick;

  assign Tx_Ready  = (state_reg == s_IDLE) & ~reset;
  assign accept    = Tx_Valid & Tx_Ready;
  assign TX_Data   = tx_data_reg;
  assign Tx_Active = tx_active_reg;
  assign Tx_Done   = tx_done_reg;

  // The timer only runs while a frame is on the line, which is exactly when Tx_Active is set.
  uart_bit_timer u_bit_timer (
    .internal_clock (internal_clock),
    .reset          (reset),
    .load           (accept),
    .enable         (tx_active_reg),
    .period         (clamp_period(CLK_PERS_BIT, PERIOD_MIN)),
    .bit_tick       (bit_tick)
  );

  always_ff @(posedge internal_clock) begin
    if (reset) begin
      state_reg      <= s_IDLE;
      shift_reg      <= '0;
      bit_index_reg  <= '0;
      stop_count_reg <= 1'b0;
      tx_data_reg    <= 1'b1;
      tx_active_reg  <= 1'b0;
      tx_done_reg    <= 1'b0;
    end else begin
      tx_done_reg <= 1'b0;
      case (state_reg)
        s_IDLE: begin
          tx_data_reg    <= 1'b1;
          tx_active_reg  <= 1'b0;
          bit_index_reg  <= '0;
          stop_count_reg <= 1'b0;
          if (accept) begin
            shift_reg     <= Tx_Byte;
            tx_data_reg   <= 1'b0;
            tx_active_reg <= 1'b1;
            state_reg     <= s_TX_START_BIT;
          end
        end
        s_TX_START_BIT: begin
          if (bit_tick) begin
            tx_data_reg   <= shift_reg[0];
            bit_index_reg <= '0;
            state_reg     <= s_TX_DATA_BIT;
          end
        end
        s_TX_DATA_BIT: begin
          if (bit_tick) begin
            if (bit_index_reg == 3'(UART_DATA_BITS - 1)) begin
              tx_data_reg <= 1'b1;
              state_reg   <= s_TX_STOP_BIT;
            end else begin
              // Buffer shifts right so the next data bit is always at index 1.
              tx_data_reg   <= shift_reg[1];
              shift_reg     <= shift_reg >> 1;
              bit_index_reg <= bit_index_reg + 3'd1;
            end
          end
        end
        s_TX_STOP_BIT: begin
          if (bit_tick) begin
            if (stop_count_reg == STOP_LAST) begin
              tx_active_reg <= 1'b0;
              tx_done_reg   <= 1'b1;
              state_reg     <= s_CLEANUP;
            end else begin
              stop_count_reg <= 1'b1;
            end
          end
        end
        s_CLEANUP: begin
          tx_data_reg <= 1'b1;
          state_reg   <= s_IDLE;
        end
        default: begin
          tx_data_reg   <= 1'b1;
          tx_active_reg <= 1'b0;
          state_reg     <= s_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
Serial UART transmit stage; drives the line consumed by the team's UART receiver.
- Accepts one byte per valid/ready handshake.
- Frames each byte as 1 start bit (low), 8 data bits LSB first, and STOP_BITS stop bits (high).
- Each bit lasts CLK_PERS_BIT clock cycles, the same runtime bit-period input the receiver uses, so both ends share one baud setting.

Parameters:
STOP_BITS, 1, number of stop bits per frame; legal values 1 or 2.
CLK_PERS_BIT_MIN, 2, lower clamp applied to the latched bit period.

Ports:
internal_clock  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
CLK_PERS_BIT  input  18  clock cycles per serial bit; sampled only at byte acceptance
Tx_Valid  input  1  upstream has a byte on Tx_Byte
Tx_Byte  input  8  byte to transmit
Tx_Ready  output  1  block can accept a byte this cycle
TX_Data  output  1  serial line out; idle high; registered
Tx_Active  output  1  high while a frame is on the line (start through last stop bit)
Tx_Done  output  1  one-cycle pulse after the last stop bit completes

Behaviour:
- Clock and reset: one clock (internal_clock). Reset is synchronous and active-high (reset).
- Reset state: state=s_IDLE, TX_Data=1, Tx_Active=0, Tx_Done=0, counters=0.
- Tx_Ready = (state==s_IDLE) & ~reset; it is combinational from state.
- Acceptance: at a rising edge with Tx_Valid & Tx_Ready, the block
  - latches Tx_Byte into a shift buffer;
  - latches the bit period as max(CLK_PERS_BIT, CLK_PERS_BIT_MIN) into an 18-bit register, call it N;
  - enters s_TX_START_BIT.
- Latency: TX_Data goes low in the cycle immediately after the accepting edge.
- Bit timing: each bit holds for exactly N cycles, using a counter that runs 0..N-1 and then advances.
- Mid-frame input changes: CLK_PERS_BIT and Tx_Byte changes during a frame have no effect.
- States:
  - s_IDLE: TX_Data=1; wait for handshake.
  - s_TX_START_BIT: TX_Data=0 for N cycles, then go to s_TX_DATA_BIT with bit index=0.
  - s_TX_DATA_BIT: TX_Data=buffer[index] for N cycles. Index 0..7; after index 7 completes, go to s_TX_STOP_BIT.
  - s_TX_STOP_BIT: TX_Data=1 for STOP_BITS*N cycles, then go to s_CLEANUP.
  - s_CLEANUP: exactly one cycle. TX_Data=1, Tx_Done=1, Tx_Ready=0. Next state is s_IDLE.
  - default: go to s_IDLE, TX_Data=1.
- Tx_Active=1 from the first start-bit cycle through the last stop-bit cycle; 0 in s_IDLE and s_CLEANUP.
- Frame length: (1+8+STOP_BITS)*N line cycles, plus 1 cleanup cycle.
- Back-to-back: with Tx_Valid held high, the next byte is accepted in the first s_IDLE cycle after s_CLEANUP. The line therefore stays high for 2 extra cycles between frames.
- Tx_Valid while busy: ignored; no byte is lost if upstream holds Tx_Valid until Tx_Ready.
- Reset mid-frame: the frame is aborted. TX_Data=1 from the next cycle, no Tx_Done pulse, and the buffer is not transmitted later.
- Reset asserted together with Tx_Valid: no acceptance (Tx_Ready=0).
- Width rules:
  - Bit counter is 18 bits; comparisons are against N-1, with no wrap because N≥2.
  - Stop-bit phase uses a 1-bit stop counter for STOP_BITS=2 rather than multiplying N.
- All outputs except Tx_Ready are registered; there are no X assignments anywhere.

Decomposition:
- Shared package uart_pkg holds:
  - the state encodings s_IDLE=3'b000, s_TX_START_BIT=3'b001, s_TX_DATA_BIT=3'b010, s_TX_STOP_BIT=3'b011, s_CLEANUP=3'b100 (same encoding as the receiver);
  - UART_DATA_BITS=8;
  - UART_BAUD_W=18.
- One natural sub-module: uart_bit_timer.
  - Loadable 18-bit down/up counter that produces a one-cycle bit_tick every N cycles and restarts on load.
  - It is reusable by the receiver.
  - The transmitter FSM consumes bit_tick.

Test Plan:
- Loopback: CLK_PERS_BIT=16, STOP_BITS=1, Tx_Byte=8'hA5, TX_Data wired to the receiver RX_Data with RX_Enable=0 -> receiver Rx_Byte=8'hA5. Tx_Done pulses at cycle 1+160 after acceptance.
- Line timing, CLK_PERS_BIT=4, byte 8'h01:
  - TX_Data = 0 for cycles 1-4, 1 for 5-8, 0 for 9-36, 1 for 37-40.
  - Tx_Active high for cycles 1-40; Tx_Done at cycle 41; Tx_Ready=1 at cycle 42.
- Back-to-back: Tx_Valid held with 8'h55 then 8'hC3, CLK_PERS_BIT=8 -> both bytes framed correctly, with exactly 2 high cycles between the first stop bit end and the second start bit.
- Reset mid-frame: assert reset in data bit 3 of 8'hFF -> TX_Data=1 next cycle, Tx_Done never pulses, Tx_Ready=1 after reset deasserts.
- Clamp and latch: CLK_PERS_BIT=0 at accept then changed to 100 mid-frame -> every bit is 2 cycles; frame is 20 cycles plus 1 cleanup.
- STOP_BITS=2, CLK_PERS_BIT=10, byte 8'h3C -> stop high for 20 cycles; Tx_Valid asserted during the stop phase is not accepted until after s_CLEANUP.
